// File: rtl/ksa_pipe_core_if.sv
// Operand/result bundle between the input register stage and the pipelined adder.
interface ksa_pipe_core_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] A;
  logic [DATA_WIDTH-1:0] B;
  logic                  Cin;
  logic                  valid_in;
  logic                  en;
  logic [DATA_WIDTH-1:0] Sum;
  logic                  Cout;
  logic                  Ovf;
  logic                  valid_out;

  modport master (
    output A, B, Cin, valid_in, en,
    input  Sum, Cout, Ovf, valid_out
  );

  modport slave (
    input  A, B, Cin, valid_in, en,
    output Sum, Cout, Ovf, valid_out
  );
endinterface

// File: rtl/ksa_pipe_core.sv
// Pipelined Kogge-Stone adder: PG rank, one register rank per prefix level, sum rank.
// All ranks advance together on en=1; valid rides a shift chain beside the data.
module ksa_pipe_core #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic           clk,
  input  logic           rst,
  ksa_pipe_core_if.slave bus
);
  localparam int unsigned L   = $clog2(DATA_WIDTH);
  localparam int unsigned MSB = DATA_WIDTH - 1;

  logic [DATA_WIDTH-1:0] g_q    [0:L];
  logic [DATA_WIDTH-1:0] p_q    [0:L];
  logic [DATA_WIDTH-1:0] praw_q [0:L];
  logic                  cin_q  [0:L];
  logic                  amsb_q [0:L];
  logic                  bmsb_q [0:L];
  logic                  vld_q  [0:L];

  logic [DATA_WIDTH-1:0] g_c, p_c;
  logic [DATA_WIDTH-1:0] g_n [1:L];
  logic [DATA_WIDTH-1:0] p_n [1:L];
  logic [DATA_WIDTH-1:0] sum_c;

  logic [DATA_WIDTH-1:0] sum_q;
  logic                  cout_q;
  logic                  ovf_q;
  logic                  vout_q;

  // Rank 0 generate/propagate, carry-in folded into bit 0's generate
  always_comb begin
    p_c    = bus.A ^ bus.B;
    g_c    = bus.A & bus.B;
    g_c[0] = (bus.A[0] & bus.B[0]) | (p_c[0] & bus.Cin);
  end

  // Prefix level k combines with the neighbour d = 2^(k-1) bits below; low d bits pass through
  always_comb begin
    for (int unsigned k = 1; k <= L; k++) begin
      g_n[k] = '0;
      p_n[k] = '0;
    end
    for (int unsigned k = 1; k <= L; k++) begin
      g_n[k] = g_q[k-1] | (p_q[k-1] & (g_q[k-1] << (32'd1 << (k - 1))));
      p_n[k] = p_q[k-1] & ((p_q[k-1] << (32'd1 << (k - 1)))
                           | ({DATA_WIDTH{1'b1}} >> (DATA_WIDTH - (32'd1 << (k - 1)))));
    end
  end

  // After the last level G_i is the carry out of bit i
  assign sum_c = praw_q[L] ^ {g_q[L][DATA_WIDTH-2:0], cin_q[L]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned k = 0; k <= L; k++) begin
        g_q[k]    <= '0;
        p_q[k]    <= '0;
        praw_q[k] <= '0;
        cin_q[k]  <= 1'b0;
        amsb_q[k] <= 1'b0;
        bmsb_q[k] <= 1'b0;
        vld_q[k]  <= 1'b0;
      end
      sum_q  <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
      vout_q <= 1'b0;
    end else if (bus.en) begin
      g_q[0]    <= g_c;
      p_q[0]    <= p_c;
      praw_q[0] <= p_c;
      cin_q[0]  <= bus.Cin;
      amsb_q[0] <= bus.A[MSB];
      bmsb_q[0] <= bus.B[MSB];
      vld_q[0]  <= bus.valid_in;
      for (int unsigned k = 1; k <= L; k++) begin
        g_q[k]    <= g_n[k];
        p_q[k]    <= p_n[k];
        praw_q[k] <= praw_q[k-1];
        cin_q[k]  <= cin_q[k-1];
        amsb_q[k] <= amsb_q[k-1];
        bmsb_q[k] <= bmsb_q[k-1];
        vld_q[k]  <= vld_q[k-1];
      end
      sum_q  <= sum_c;
      cout_q <= g_q[L][MSB];
      ovf_q  <= (amsb_q[L] == bmsb_q[L]) && (sum_c[MSB] != amsb_q[L]);
      vout_q <= vld_q[L];
    end
  end

  assign bus.Sum       = sum_q;
  assign bus.Cout      = cout_q;
  assign bus.Ovf       = ovf_q;
  assign bus.valid_out = vout_q;
endmodule

// File: tb/tb_ksa_pipe_core.sv
// Bench for ksa_pipe_core: directed vector table, random stream with stalls/bubbles,
// and asynchronous reset sequences, all checked against an ideal delay-line adder model.
module tb_ksa_pipe_core;
  localparam int unsigned W   = 32;
  localparam int unsigned LAT = 7;

  typedef struct packed {
    logic         v;
    logic [W-1:0] s;
    logic         c;
    logic         o;
  } res_t;

  typedef struct packed {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] exp_s;
    logic         exp_c;
    logic         exp_o;
  } vec_t;

  logic clk;
  logic rst;
  int   total;
  int   bad;
  res_t pipe [LAT];

  ksa_pipe_core_if #(.DATA_WIDTH(W)) bus ();

  ksa_pipe_core #(.DATA_WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic res_t ref_add(logic [W-1:0] a, logic [W-1:0] b, logic cin, logic v);
    res_t r;
    logic [W:0] full;
    full = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
    r.v  = v;
    r.s  = full[W-1:0];
    r.c  = full[W];
    r.o  = (a[W-1] == b[W-1]) && (r.s[W-1] != a[W-1]);
    return r;
  endfunction

  function automatic void cmp(string name, logic [W-1:0] act, logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endfunction

  task automatic model_clear();
    for (int i = 0; i < int'(LAT); i++) pipe[i] = '0;
  endtask

  // Outputs must match the oldest slot of the ideal delay line every cycle
  task automatic check(string tag);
    res_t e;
    e = pipe[LAT-1];
    cmp({tag, "_vld"}, W'(bus.valid_out), W'(e.v));
    cmp({tag, "_sum"}, bus.Sum, e.s);
    cmp({tag, "_cout"}, W'(bus.Cout), W'(e.c));
    cmp({tag, "_ovf"}, W'(bus.Ovf), W'(e.o));
  endtask

  // Called at a negedge: drive, take one rising edge, check at the next negedge
  task automatic cycle(logic [W-1:0] a, logic [W-1:0] b, logic cin, logic v, logic e, string tag);
    bus.A        = a;
    bus.B        = b;
    bus.Cin      = cin;
    bus.valid_in = v;
    bus.en       = e;
    @(posedge clk);
    if (rst && e) begin
      for (int i = int'(LAT) - 1; i > 0; i--) pipe[i] = pipe[i-1];
      pipe[0] = ref_add(a, b, cin, v);
    end
    @(negedge clk);
    check(tag);
  endtask

  task automatic idle(int n, string tag);
    for (int i = 0; i < n; i++) cycle('0, '0, 1'b0, 1'b0, 1'b1, tag);
  endtask

  task automatic async_reset(string tag);
    #2 rst = 1'b0;
    model_clear();
    #1;
    cmp({tag, "_rst_vld"}, W'(bus.valid_out), '0);
    cmp({tag, "_rst_sum"}, bus.Sum, '0);
    cmp({tag, "_rst_cout"}, W'(bus.Cout), '0);
    cmp({tag, "_rst_ovf"}, W'(bus.Ovf), '0);
    @(negedge clk);
    // en=0 alongside reset must not keep anything alive
    bus.en = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check({tag, "_held"});
    rst = 1'b1;
  endtask

  vec_t vecs [7];
  int   issued;
  logic e, v;

  initial begin
    total = 0;
    bad   = 0;
    model_clear();
    bus.A = '0; bus.B = '0; bus.Cin = 1'b0; bus.valid_in = 1'b0; bus.en = 1'b0;
    rst = 1'b0;

    vecs[0] = '{32'h0000_0001, 32'h0000_0001, 1'b0, 32'h0000_0002, 1'b0, 1'b0};
    vecs[1] = '{32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1, 1'b0};
    vecs[2] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0};
    vecs[3] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
    vecs[4] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1};
    vecs[5] = '{32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 32'hACF1_3568, 1'b0, 1'b0};
    vecs[6] = '{32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b1};

    repeat (2) @(negedge clk);
    check("por");
    rst = 1'b1;
    idle(LAT, "post_por");

    // Directed vectors: result appears six en=1 edges after the issuing edge
    foreach (vecs[i]) begin
      cycle(vecs[i].a, vecs[i].b, vecs[i].cin, 1'b1, 1'b1, $sformatf("vec%0d_issue", i));
      idle(int'(LAT) - 1, $sformatf("vec%0d_lat", i));
      cmp($sformatf("vec%0d_tbl_vld", i), W'(bus.valid_out), W'(1'b1));
      cmp($sformatf("vec%0d_tbl_sum", i), bus.Sum, vecs[i].exp_s);
      cmp($sformatf("vec%0d_tbl_cout", i), W'(bus.Cout), W'(vecs[i].exp_c));
      cmp($sformatf("vec%0d_tbl_ovf", i), W'(bus.Ovf), W'(vecs[i].exp_o));
      idle(1, $sformatf("vec%0d_after", i));
    end

    // Reset with a full pipeline of valid ops
    for (int i = 0; i < int'(LAT); i++)
      cycle($urandom, $urandom, 1'($urandom), 1'b1, 1'b1, "fill");
    async_reset("full");
    idle(int'(LAT) - 1, "after_full_rst");

    // Random stream with stalls and bubbles
    issued = 0;
    while (issued < 100) begin
      e = ($urandom_range(0, 3) != 0);
      v = ($urandom_range(0, 4) != 0);
      cycle($urandom, $urandom, 1'($urandom), v, e, "stream");
      if (e && v) issued++;
    end
    idle(int'(LAT), "drain");

    // Reset mid-stream with four ops in flight, then one op after release
    for (int i = 0; i < 4; i++)
      cycle($urandom, $urandom, 1'($urandom), 1'b1, 1'b1, "inflight");
    async_reset("mid");
    cycle(32'hDEAD_BEEF, 32'h2152_4111, 1'b1, 1'b1, 1'b1, "post_rst_issue");
    idle(int'(LAT) - 1, "post_rst_lat");
    cmp("post_rst_tbl_vld", W'(bus.valid_out), W'(1'b1));
    cmp("post_rst_tbl_sum", bus.Sum, 32'h0000_0001);
    cmp("post_rst_tbl_cout", W'(bus.Cout), W'(1'b1));
    idle(3, "tail");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
